// File: rtl/eth_udp_pktgen_if.sv
// MAC TX AXI-Stream beat bus (64-bit data, byte enables, last, ready).
// The generator drives through master; the MAC side uses slave.
interface eth_udp_pktgen_if;
  logic        tvalid;
  logic        tready;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;

  modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/eth_udp_pktgen.sv
// UDP/IPv4 frame generator for the 10G MAC TX stream; one LOAD cycle precedes each frame.
// Beats are held stable while tready is low; the beat index advances only on handshake.
module eth_udp_pktgen #(
  parameter logic [47:0] ETH_DST       = 48'h90_E2_BA_5D_8D_C8,
  parameter logic [47:0] ETH_SRC       = 48'h00_11_22_33_44_55,
  parameter logic [31:0] IP_SADDR      = 32'hC0A8_016F,
  parameter logic [31:0] IP_DADDR      = 32'hC0A8_017A,
  parameter logic [15:0] UDP_SPORT     = 16'd3776,
  parameter logic [15:0] UDP_DPORT     = 16'd3776,
  parameter logic [15:0] MIN_FRAME_LEN = 16'd60,
  parameter logic [15:0] MAX_FRAME_LEN = 16'd1514
) (
  input  logic                   clk156,
  input  logic                   reset,
  input  logic                   cfg_start,
  input  logic                   cfg_stop,
  input  logic [15:0]            cfg_frame_len,
  input  logic [31:0]            cfg_gap,
  input  logic [31:0]            cfg_count,
  eth_udp_pktgen_if.master       s_axis_tx,
  output logic                   busy,
  output logic [31:0]            tx_frames
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  state_t      state, state_nxt;
  logic [15:0] len_q;
  logic [31:0] gap_q;
  logic [31:0] count_q;
  logic [31:0] gap_cnt;
  logic [7:0]  nbeats;
  logic [7:0]  beat;
  logic [15:0] ip_check;
  logic        stop_pend;

  logic [15:0] len_clamp;
  logic [15:0] tot_len_new;
  logic        xfer;
  logic        last_beat;
  logic        frame_done;
  logic        stop_now;
  logic        count_hit;

  function automatic logic [15:0] ip_csum(input logic [15:0] tot_len);
    logic [19:0] s;
    s = 20'h04500 + 20'(tot_len) + 20'h04011
      + 20'(IP_SADDR[31:16]) + 20'(IP_SADDR[15:0])
      + 20'(IP_DADDR[31:16]) + 20'(IP_DADDR[15:0]);
    s = 20'(s[15:0]) + 20'(s[19:16]);
    s = 20'(s[15:0]) + 20'(s[19:16]);
    return ~s[15:0];
  endfunction

  assign len_clamp   = (cfg_frame_len < MIN_FRAME_LEN) ? MIN_FRAME_LEN :
                       (cfg_frame_len > MAX_FRAME_LEN) ? MAX_FRAME_LEN : cfg_frame_len;
  assign tot_len_new = len_clamp - 16'd14;
  assign xfer        = (state == SEND) && s_axis_tx.tready;
  assign last_beat   = (beat == nbeats - 8'd1);
  assign frame_done  = xfer && last_beat;
  assign stop_now    = stop_pend || cfg_stop;
  assign count_hit   = (count_q != 32'd0) && (tx_frames + 32'd1 == count_q);

  always_ff @(posedge clk156) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cfg_start) state_nxt = LOAD;
      LOAD: state_nxt = stop_now ? IDLE : SEND;
      SEND: begin
        if (frame_done) begin
          if (stop_now || count_hit) state_nxt = IDLE;
          else if (gap_q == 32'd0)   state_nxt = LOAD;
          else                       state_nxt = GAP;
        end
      end
      GAP: begin
        if (stop_now)                state_nxt = IDLE;
        else if (gap_cnt == 32'd0)   state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The sequence number stamped into each frame equals frames completed so far in the run.
  always_ff @(posedge clk156) begin
    if (reset) begin
      len_q     <= '0;
      gap_q     <= '0;
      count_q   <= '0;
      gap_cnt   <= '0;
      nbeats    <= '0;
      beat      <= '0;
      ip_check  <= '0;
      stop_pend <= 1'b0;
      tx_frames <= '0;
    end else begin
      case (state)
        IDLE: begin
          stop_pend <= 1'b0;
          if (cfg_start) begin
            count_q   <= cfg_count;
            tx_frames <= '0;
          end
        end
        LOAD: begin
          len_q    <= len_clamp;
          gap_q    <= cfg_gap;
          nbeats   <= 8'((len_clamp + 16'd7) >> 3);
          beat     <= '0;
          ip_check <= ip_csum(tot_len_new);
        end
        SEND: begin
          if (xfer) begin
            if (last_beat) begin
              beat      <= '0;
              tx_frames <= tx_frames + 32'd1;
              gap_cnt   <= gap_q - 32'd1;
            end else begin
              beat <= beat + 8'd1;
            end
          end
        end
        GAP: gap_cnt <= gap_cnt - 32'd1;
        default: ;
      endcase
      if (cfg_stop && state != IDLE) stop_pend <= 1'b1;
    end
  end

  logic [383:0] hdr;
  logic [15:0]  tot_len;
  logic [15:0]  udp_len;

  assign tot_len = len_q - 16'd14;
  assign udp_len = len_q - 16'd34;
  // First 48 wire bytes, byte 0 in the top bits; everything past byte 47 is zero padding.
  assign hdr = {ETH_DST, ETH_SRC, 16'h0800,
                8'h45, 8'h00, tot_len, 16'h0000, 16'h0000, 8'd64, 8'd17, ip_check,
                IP_SADDR, IP_DADDR,
                UDP_SPORT, UDP_DPORT, udp_len, 16'h0000,
                tx_frames, 16'h0000};

  always_comb begin
    busy             = (state != IDLE);
    s_axis_tx.tvalid = (state == SEND);
    s_axis_tx.tlast  = (state == SEND) && last_beat;
    s_axis_tx.tkeep  = 8'h00;
    s_axis_tx.tdata  = 64'd0;
    if (state == SEND) begin
      if (!last_beat || len_q[2:0] == 3'd0) s_axis_tx.tkeep = 8'hFF;
      else s_axis_tx.tkeep = 8'hFF >> (4'd8 - {1'b0, len_q[2:0]});
      if (beat < 8'd6) begin
        for (int i = 0; i < 8; i++) begin
          s_axis_tx.tdata[8*i +: 8] = hdr[383 - 64*int'(beat[2:0]) - 8*i -: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_udp_pktgen.sv
// Directed bench for eth_udp_pktgen: a byte-level frame model checks every handshake,
// plus literal expectations for checksums, keeps, gaps, stop and reset behaviour.
module tb_eth_udp_pktgen;
  logic        clk156 = 1'b0;
  logic        reset;
  logic        cfg_start, cfg_stop;
  logic [15:0] cfg_frame_len;
  logic [31:0] cfg_gap, cfg_count;
  logic        busy;
  logic [31:0] tx_frames;

  eth_udp_pktgen_if bus();

  eth_udp_pktgen dut (
    .clk156(clk156), .reset(reset),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_frame_len(cfg_frame_len), .cfg_gap(cfg_gap), .cfg_count(cfg_count),
    .s_axis_tx(bus), .busy(busy), .tx_frames(tx_frames)
  );

  always #3 clk156 = ~clk156;

  localparam logic [47:0] M_DST  = 48'h90E2BA5D8DC8;
  localparam logic [47:0] M_SRC  = 48'h001122334455;
  localparam logic [31:0] M_SIP  = 32'hC0A8016F;
  localparam logic [31:0] M_DIP  = 32'hC0A8017A;
  localparam logic [15:0] M_PORT = 16'd3776;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  logic [7:0]  exp_frame [0:1519];
  int          m_len, m_beat, m_seq, frames_seen, last_beats;
  logic [7:0]  last_keep;
  logic [63:0] cap_beat2, cap_beat3, cap_beat5;
  int          cyc = 0, t_last = 0;
  bit          prev_hold;
  logic [63:0] prev_dat;
  logic [7:0]  prev_keep;
  logic        prev_last;
  bit          counting;
  int          lowcnt, last_gap;
  bit          rand_rdy;

  function automatic int clampl(input int x);
    return (x < 60) ? 60 : ((x > 1514) ? 1514 : x);
  endfunction

  task automatic build_frame(input int len, input int sq);
    int s;
    logic [15:0] tot, ul, ck;
    logic [31:0] sqv;
    for (int p = 0; p < 1520; p++) exp_frame[p] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      exp_frame[i]     = M_DST[8*(5-i) +: 8];
      exp_frame[6 + i] = M_SRC[8*(5-i) +: 8];
    end
    exp_frame[12] = 8'h08;
    exp_frame[14] = 8'h45;
    tot = 16'(len - 14);
    exp_frame[16] = tot[15:8];
    exp_frame[17] = tot[7:0];
    exp_frame[22] = 8'd64;
    exp_frame[23] = 8'd17;
    for (int i = 0; i < 4; i++) begin
      exp_frame[26 + i] = M_SIP[8*(3-i) +: 8];
      exp_frame[30 + i] = M_DIP[8*(3-i) +: 8];
    end
    exp_frame[34] = M_PORT[15:8];
    exp_frame[35] = M_PORT[7:0];
    exp_frame[36] = M_PORT[15:8];
    exp_frame[37] = M_PORT[7:0];
    ul = 16'(len - 34);
    exp_frame[38] = ul[15:8];
    exp_frame[39] = ul[7:0];
    sqv = 32'(sq);
    for (int i = 0; i < 4; i++) exp_frame[42 + i] = sqv[8*(3-i) +: 8];
    s = 0;
    for (int w = 0; w < 10; w++) s = s + int'({exp_frame[14 + 2*w], exp_frame[15 + 2*w]});
    while (s > 32'h0000FFFF) s = (s & 32'h0000FFFF) + (s >> 16);
    ck = ~16'(s);
    exp_frame[24] = ck[15:8];
    exp_frame[25] = ck[7:0];
  endtask

  always @(posedge clk156) cyc++;

  initial begin
    bus.tready = 1'b1;
    forever begin
      @(posedge clk156);
      #1;
      bus.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Per-cycle compare against the frame model
  always @(negedge clk156) begin
    int          nbytes;
    logic [7:0]  ekeep;
    logic        elast;
    logic [63:0] edat, mask;
    if (reset) begin
      m_beat    = 0;
      prev_hold = 0;
      counting  = 0;
    end else begin
      if (cfg_start && !busy) begin
        m_seq = 0; m_beat = 0; frames_seen = 0; counting = 0;
      end
      if (prev_hold) begin
        check("hold_valid", 64'(bus.tvalid), 64'd1);
        check("hold_data", bus.tdata, prev_dat);
        check("hold_keep", 64'(bus.tkeep), 64'(prev_keep));
        check("hold_last", 64'(bus.tlast), 64'(prev_last));
      end
      if (bus.tvalid) begin
        if (counting) begin
          last_gap = lowcnt;
          counting = 0;
        end
        if (m_beat == 0) begin
          m_len = clampl(int'(cfg_frame_len));
          build_frame(m_len, m_seq);
        end
        nbytes = m_len - 8*m_beat;
        if (nbytes > 8) nbytes = 8;
        ekeep = 8'((1 << nbytes) - 1);
        elast = (8*(m_beat + 1) >= m_len);
        edat = 64'd0;
        mask = 64'd0;
        for (int i = 0; i < 8; i++) begin
          if (i < nbytes) begin
            edat[8*i +: 8] = exp_frame[8*m_beat + i];
            mask[8*i +: 8] = 8'hFF;
          end
        end
        if (bus.tready) begin
          check("beat_keep", 64'(bus.tkeep), 64'(ekeep));
          check("beat_last", 64'(bus.tlast), 64'(elast));
          check("beat_data", bus.tdata & mask, edat);
          if (m_beat == 2) cap_beat2 = bus.tdata;
          if (m_beat == 3) cap_beat3 = bus.tdata;
          if (m_beat == 5) cap_beat5 = bus.tdata;
          if (elast) begin
            frames_seen++;
            m_seq++;
            last_beats = m_beat + 1;
            last_keep  = bus.tkeep;
            t_last     = cyc;
            m_beat     = 0;
            counting   = 1;
            lowcnt     = 0;
          end else begin
            m_beat++;
          end
        end
      end else if (counting) begin
        lowcnt++;
      end
      prev_hold = bus.tvalid && !bus.tready;
      prev_dat  = bus.tdata;
      prev_keep = bus.tkeep;
      prev_last = bus.tlast;
    end
  end

  task automatic start_run(input int len, input int gap, input int count);
    @(posedge clk156); #1;
    cfg_frame_len = 16'(len);
    cfg_gap       = 32'(gap);
    cfg_count     = 32'(count);
    cfg_start     = 1'b1;
    @(posedge clk156); #1;
    cfg_start     = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int k = 0;
    @(negedge clk156);
    while (busy && k < maxc) begin
      @(negedge clk156);
      k++;
    end
    if (busy) check(name, 64'(busy), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nv;
    reset = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0;
    cfg_frame_len = 16'd60; cfg_gap = '0; cfg_count = '0;
    rand_rdy = 0;
    repeat (3) @(posedge clk156);
    #1 reset = 1'b0;
    @(negedge clk156);
    check("rst_tvalid", 64'(bus.tvalid), 64'd0);
    check("rst_tlast", 64'(bus.tlast), 64'd0);
    check("rst_tkeep", 64'(bus.tkeep), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tx_frames", 64'(tx_frames), 64'd0);

    // Minimum frame, single shot
    start_run(60, 0, 1);
    wait_idle("t60_timeout", 200);
    check("t60_busy_fall", 64'(cyc - t_last), 64'd1);
    check("t60_beats", 64'(last_beats), 64'd8);
    check("t60_last_keep", 64'(last_keep), 64'h0F);
    check("t60_ipcheck", 64'(cap_beat3[15:0]), 64'h85F6);
    check("t60_tx_frames", 64'(tx_frames), 64'd1);
    check("model_ck_hi", 64'(exp_frame[24]), 64'hF6);
    check("model_ck_lo", 64'(exp_frame[25]), 64'h85);

    // Maximum frame, two frames with a gap
    start_run(1514, 5, 2);
    wait_idle("t1514_timeout", 1000);
    check("t1514_beats", 64'(last_beats), 64'd190);
    check("t1514_last_keep", 64'(last_keep), 64'h03);
    check("t1514_ipcheck", 64'(cap_beat3[15:0]), 64'hD7F0);
    check("t1514_gap", 64'(last_gap), 64'd6);
    check("t1514_seq1", 64'(cap_beat5[47:16]), 64'h01000000);
    check("t1514_tx_frames", 64'(tx_frames), 64'd2);
    check("t1514_frames_seen", 64'(frames_seen), 64'd2);

    // Length clamping
    start_run(20, 0, 1);
    wait_idle("t20_timeout", 200);
    check("t20_tot_len", 64'(cap_beat2[15:0]), 64'h2E00);
    check("t20_beats", 64'(last_beats), 64'd8);
    start_run(2000, 0, 1);
    wait_idle("t2000_timeout", 1000);
    check("t2000_tot_len", 64'(cap_beat2[15:0]), 64'hDC05);
    check("t2000_beats", 64'(last_beats), 64'd190);

    // Random backpressure
    rand_rdy = 1;
    start_run(100, 2, 3);
    wait_idle("trand_timeout", 3000);
    rand_rdy = 0;
    check("trand_tx_frames", 64'(tx_frames), 64'd3);
    check("trand_frames_seen", 64'(frames_seen), 64'd3);
    check("trand_beats", 64'(last_beats), 64'd13);
    check("trand_last_keep", 64'(last_keep), 64'h0F);

    // Free-running, stopped in the middle of frame 4
    start_run(60, 3, 0);
    k = 0;
    while (!(frames_seen == 3 && m_beat >= 2) && k < 500) begin
      @(negedge clk156);
      k++;
    end
    check("tstop_reach_frame4", 64'(frames_seen), 64'd3);
    @(posedge clk156); #1 cfg_stop = 1'b1;
    @(posedge clk156); #1 cfg_stop = 1'b0;
    wait_idle("tstop_timeout", 200);
    check("tstop_tx_frames", 64'(tx_frames), 64'd4);
    check("tstop_frames_seen", 64'(frames_seen), 64'd4);
    check("tstop_beats", 64'(last_beats), 64'd8);
    nv = 0;
    repeat (20) begin
      @(negedge clk156);
      if (bus.tvalid) nv++;
    end
    check("tstop_no_tvalid", 64'(nv), 64'd0);
    start_run(60, 0, 1);
    wait_idle("trestart_timeout", 200);
    check("trestart_seq0", 64'(cap_beat5[47:16]), 64'd0);
    check("trestart_tx_frames", 64'(tx_frames), 64'd1);

    // Start and stop in the same idle cycle: start wins
    @(posedge clk156); #1;
    cfg_frame_len = 16'd60; cfg_gap = '0; cfg_count = 32'd1;
    cfg_start = 1'b1; cfg_stop = 1'b1;
    @(posedge clk156); #1;
    cfg_start = 1'b0; cfg_stop = 1'b0;
    @(negedge clk156);
    check("tboth_busy", 64'(busy), 64'd1);
    wait_idle("tboth_timeout", 200);
    check("tboth_tx_frames", 64'(tx_frames), 64'd1);

    // Reset in the middle of a long frame
    start_run(1514, 0, 1);
    repeat (10) @(negedge clk156);
    @(posedge clk156); #1 reset = 1'b1;
    @(posedge clk156); #1 reset = 1'b0;
    @(negedge clk156);
    check("trst_tvalid", 64'(bus.tvalid), 64'd0);
    check("trst_tlast", 64'(bus.tlast), 64'd0);
    check("trst_busy", 64'(busy), 64'd0);
    check("trst_tx_frames", 64'(tx_frames), 64'd0);
    start_run(60, 0, 1);
    wait_idle("trst_new_timeout", 200);
    check("trst_new_tx_frames", 64'(tx_frames), 64'd1);
    check("trst_new_beats", 64'(last_beats), 64'd8);
    check("trst_new_ipcheck", 64'(cap_beat3[15:0]), 64'h85F6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
